// File: rtl/qed_mem_scan_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : qed_mem_scan_checker_if
// Brief    : Control, status and dual read-port bundle for the QED memory scan checker.
// Revision : 1.0
// ============================================================================
interface qed_mem_scan_checker_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH/2),
    parameter int CNT_W  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              start;
    logic              stop_on_first;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy;
    logic              done;
    logic              pass;
    logic              mismatch;
    logic [IDX_W-1:0]  first_idx;
    logic [DATA_W-1:0] first_orig;
    logic [DATA_W-1:0] first_dup;
    logic [CNT_W-1:0]  err_count;

    modport master (
        input  start, stop_on_first, rd_data_a, rd_data_b,
        output rd_en, rd_addr_a, rd_addr_b, busy, done, pass, mismatch,
               first_idx, first_orig, first_dup, err_count
    );

    modport slave (
        output start, stop_on_first, rd_data_a, rd_data_b,
        input  rd_en, rd_addr_a, rd_addr_b, busy, done, pass, mismatch,
               first_idx, first_orig, first_dup, err_count
    );
endinterface
`default_nettype wire

// File: rtl/qed_mem_scan_checker.sv
`default_nettype none
// ============================================================================
// Module   : qed_mem_scan_checker
// Brief    : Walks original/duplicate memory pairs and reports QED consistency.
// Revision : 1.0
// ============================================================================
module qed_mem_scan_checker #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH/2),
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    qed_mem_scan_checker_if.master bus
);
    localparam int               HALF     = DEPTH / 2;
    localparam int               ADDR_W   = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              stop_q, stop_d;
    logic              pass_q, pass_d;
    logic              mis_q, mis_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [DATA_W-1:0] forig_q, forig_d;
    logic [DATA_W-1:0] fdup_q, fdup_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic rd_en_w, busy_w, done_w, accept_w, cmp_miss_w, stop_hit_w;

    assign cmp_miss_w = valid_q && (bus.rd_data_a != bus.rd_data_b);
    assign stop_hit_w = stop_q && cmp_miss_w;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stop_d   = stop_q;
        rd_en_w  = 1'b0;
        busy_w   = 1'b0;
        done_w   = 1'b0;
        accept_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SCAN;
                    addr_d   = '0;
                    stop_d   = bus.stop_on_first;
                    accept_w = 1'b1;
                end
            end
            S_SCAN: begin
                // A stop-on-first hit suppresses this cycle's read so nothing is left in flight.
                if (stop_hit_w) begin
                    done_w  = 1'b1;
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else begin
                    rd_en_w = 1'b1;
                    busy_w  = 1'b1;
                    if (addr_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                done_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = rd_en_w;
        idx_d   = rd_en_w ? addr_q : idx_q;
        pass_d  = pass_q;
        mis_d   = mis_q;
        fidx_d  = fidx_q;
        forig_d = forig_q;
        fdup_d  = fdup_q;
        cnt_d   = cnt_q;
        if (accept_w) begin
            pass_d  = 1'b0;
            mis_d   = 1'b0;
            fidx_d  = '0;
            forig_d = '0;
            fdup_d  = '0;
            cnt_d   = '0;
        end else if (cmp_miss_w) begin
            if (!mis_q) begin
                fidx_d  = idx_q;
                forig_d = bus.rd_data_a;
                fdup_d  = bus.rd_data_b;
            end
            mis_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Uses mismatch flags rather than the counter so saturation cannot hide a failure.
        if (done_w) begin
            pass_d = !(mis_q || cmp_miss_w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            stop_q  <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= 1'b0;
            fidx_q  <= '0;
            forig_q <= '0;
            fdup_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            stop_q  <= stop_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
            fidx_q  <= fidx_d;
            forig_q <= forig_d;
            fdup_q  <= fdup_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rd_en      = rd_en_w;
    assign bus.rd_addr_a  = rd_en_w ? ADDR_W'(addr_q) : '0;
    assign bus.rd_addr_b  = rd_en_w ? ADDR_W'(addr_q) + ADDR_W'(HALF) : '0;
    assign bus.busy       = busy_w;
    assign bus.done       = done_w;
    assign bus.pass       = pass_q;
    assign bus.mismatch   = mis_q;
    assign bus.first_idx  = fidx_q;
    assign bus.first_orig = forig_q;
    assign bus.first_dup  = fdup_q;
    assign bus.err_count  = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_qed_mem_scan_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_qed_mem_scan_checker
// Brief    : Self-checking bench: table vectors, random scans vs. a reference model, corner sequences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_qed_mem_scan_checker;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int HALF   = 16;
    localparam int IDX_W  = 4;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qed_mem_scan_checker_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(8)) bus ();
    qed_mem_scan_checker_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(3)) bus_s ();

    qed_mem_scan_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    qed_mem_scan_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.master)
    );

    logic [31:0] mem [DEPTH];

    assign bus_s.start         = bus.start;
    assign bus_s.stop_on_first = bus.stop_on_first;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem[bus.rd_addr_a];
            bus.rd_data_b <= mem[bus.rd_addr_b];
        end
    end
    always @(posedge clk) begin
        if (bus_s.rd_en) begin
            bus_s.rd_data_a <= mem[bus_s.rd_addr_a];
            bus_s.rd_data_b <= mem[bus_s.rd_addr_b];
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int done_cyc, s_done_cyc, n_done;
    bit addr_bad;
    bit busy_h [64];
    bit rden_h [64];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Issues a start at the current negedge; returns at the negedge one cycle after done.
    task automatic run_scan(input logic stop, input int inj1, input int inj2);
        done_cyc   = -1;
        s_done_cyc = -1;
        n_done     = 0;
        addr_bad   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            busy_h[i] = 1'b0;
            rden_h[i] = 1'b0;
        end
        bus.stop_on_first = stop;
        bus.start         = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = (c == inj1) || (c == inj2);
            busy_h[c] = bus.busy;
            rden_h[c] = bus.rd_en;
            if (bus.rd_en && (bus.rd_addr_a != AW'(c - 1) || bus.rd_addr_b != AW'(c - 1 + HALF)))
                addr_bad = 1'b1;
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus_s.done && s_done_cyc < 0) s_done_cyc = c;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int exp_done, input int exp_first,
                              input int exp_err, input int exp_sat, input bit exp_pass,
                              input logic [31:0] fo, input logic [31:0] fd);
        bit win_ok = 1'b1;
        for (int c = 1; c <= exp_done && c < 64; c++) begin
            if (busy_h[c] != (c < exp_done)) win_ok = 1'b0;
            if (rden_h[c] != (c < exp_done)) win_ok = 1'b0;
        end
        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " sat_done_cycle"}, s_done_cyc, exp_done);
        chk({tag, " busy_rden_window"}, win_ok, 1);
        chk({tag, " addr_seq_bad"}, addr_bad, 0);
        chk({tag, " pass"}, bus.pass, exp_pass);
        chk({tag, " mismatch"}, bus.mismatch, !exp_pass);
        chk({tag, " first_idx"}, bus.first_idx, exp_first);
        chk({tag, " first_orig"}, bus.first_orig, fo);
        chk({tag, " first_dup"}, bus.first_dup, fd);
        chk({tag, " err_count"}, bus.err_count, exp_err);
        chk({tag, " sat_err_count"}, bus_s.err_count, exp_sat);
        chk({tag, " sat_pass"}, bus_s.pass, exp_pass);
        chk({tag, " sat_first_idx"}, bus_s.first_idx, exp_first);
    endtask

    // Reference: list mismatching pairs in scan order and apply the stop/saturation rules.
    task automatic model(input logic stop, output int exp_done, output int first, output int err,
                         output int err_sat, output bit pass_o, output logic [31:0] fo,
                         output logic [31:0] fd);
        int cnt = 0;
        int k   = HALF - 1;
        first = -1;
        fo = '0;
        fd = '0;
        for (int i = 0; i < HALF; i++) begin
            if (mem[i] != mem[i + HALF]) begin
                if (first < 0) begin
                    first = i;
                    fo = mem[i];
                    fd = mem[i + HALF];
                end
                cnt++;
                if (stop) begin
                    k = i;
                    break;
                end
            end
        end
        exp_done = k + 2;
        err      = (cnt > 255) ? 255 : cnt;
        err_sat  = (cnt > 7) ? 7 : cnt;
        pass_o   = (cnt == 0);
        if (first < 0) first = 0;
    endtask

    typedef struct {
        logic        stop;
        logic [15:0] mask;
        int          exp_done;
        int          exp_first;
        int          exp_err;
        int          exp_sat;
        bit          exp_pass;
    } vec_t;

    vec_t tbl [8];

    task automatic fill_equal();
        for (int i = 0; i < HALF; i++) begin
            mem[i]        = $urandom;
            mem[i + HALF] = mem[i];
        end
    endtask

    initial begin
        int          e_done, e_first, e_err, e_sat;
        bit          e_pass;
        logic [31:0] e_fo, e_fd;
        int          nd;

        tbl[0] = '{1'b0, 16'h0000, 17, 0, 0, 0, 1'b1};
        tbl[1] = '{1'b0, 16'h0020, 17, 5, 1, 1, 1'b0};
        tbl[2] = '{1'b1, 16'h0208,  5, 3, 1, 1, 1'b0};
        tbl[3] = '{1'b0, 16'hFFFF, 17, 0, 16, 7, 1'b0};
        tbl[4] = '{1'b1, 16'h0000, 17, 0, 0, 0, 1'b1};
        tbl[5] = '{1'b1, 16'h8000, 17, 15, 1, 1, 1'b0};
        tbl[6] = '{1'b0, 16'h8001, 17, 0, 2, 2, 1'b0};
        tbl[7] = '{1'b1, 16'h0001,  2, 0, 1, 1, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop_on_first = 1'b0;
        fill_equal();
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset rd_en", bus.rd_en, 0);
        chk("reset pass", bus.pass, 0);
        chk("reset err_count", bus.err_count, 0);
        chk("reset rd_addr_b", bus.rd_addr_b, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[t]) begin
            fill_equal();
            for (int i = 0; i < HALF; i++) begin
                if (tbl[t].mask[i]) begin
                    mem[i]        = 32'h1;
                    mem[i + HALF] = 32'h2;
                end
            end
            run_scan(tbl[t].stop, 0, 0);
            check_scan($sformatf("vec%0d", t), tbl[t].exp_done, tbl[t].exp_first, tbl[t].exp_err,
                       tbl[t].exp_sat, tbl[t].exp_pass,
                       tbl[t].exp_pass ? 32'h0 : 32'h1, tbl[t].exp_pass ? 32'h0 : 32'h2);
        end

        for (int r = 0; r < 20; r++) begin
            int rate = (r % 4 == 0) ? 3 : 1;
            for (int i = 0; i < HALF; i++) begin
                mem[i]        = $urandom;
                mem[i + HALF] = mem[i];
                if ($urandom_range(0, 3) < rate) mem[i + HALF] = mem[i] ^ ($urandom | 32'h1);
            end
            begin
                logic stop = 1'($urandom_range(0, 1));
                model(stop, e_done, e_first, e_err, e_sat, e_pass, e_fo, e_fd);
                run_scan(stop, 0, 0);
                check_scan($sformatf("rand%0d", r), e_done, e_first, e_err, e_sat, e_pass, e_fo, e_fd);
            end
        end

        // Reset in cycle 6 of a scan that has already recorded a mismatch.
        fill_equal();
        mem[1 + HALF] = ~mem[1];
        bus.stop_on_first = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst mismatch", bus.mismatch, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst busy", bus.busy, 0);
        chk("mid_rst done", bus.done, 0);
        chk("mid_rst rd_en", bus.rd_en, 0);
        chk("mid_rst mismatch", bus.mismatch, 0);
        chk("mid_rst err_count", bus.err_count, 0);
        chk("mid_rst first_orig", bus.first_orig, 0);
        chk("mid_rst rd_addr_a", bus.rd_addr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        chk("post_rst no_activity", nd, 0);
        fill_equal();
        run_scan(1'b0, 0, 0);
        check_scan("after_rst", 17, 0, 0, 0, 1'b1, 32'h0, 32'h0);

        // Starts while busy and in the done cycle are ignored; the following cycle is accepted.
        fill_equal();
        run_scan(1'b0, 3, 17);
        check_scan("restart_ignored", 17, 0, 0, 0, 1'b1, 32'h0, 32'h0);
        mem[7 + HALF] = ~mem[7];
        run_scan(1'b0, 0, 0);
        check_scan("restart_accepted", 17, 7, 1, 1, 1'b0, mem[7], mem[7 + HALF]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
